// File: rtl/da_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// da_pkg
// Shared definitions for the distributed-arithmetic address generator:
//   - default sizing for activation width, vector length and bit-index width
//   - the generator state encoding
//   - slice_addr(): turns one bit-plane column (K bits) into the K-1 bit
//     relative-sign address used by the LUT stage. Bit j of the result pairs
//     with weight j+1.
// -----------------------------------------------------------------------------
package da_pkg;

  localparam int DATA_WIDTH_A_DEF = 16;
  localparam int K_DEF            = 9;
  localparam int T_W_DEF          = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } da_gen_state_t;

  // Relative-sign address for one bit-plane: a set bit means lane i agrees
  // with lane 0 at this bit position.
  function automatic logic [K_DEF-2:0] slice_addr(input logic [K_DEF-1:0] bits);
    logic [K_DEF-2:0] addr;
    addr = '0;
    for (int i = 1; i < K_DEF; i++) begin
      addr[i-1] = ~(bits[i] ^ bits[0]);
    end
    return addr;
  endfunction

endpackage

// File: rtl/da_addr_gen_sreg.sv
// -----------------------------------------------------------------------------
// da_bitplane_sreg
// K-lane arithmetic right-shift register holding one activation vector.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset, clears all lanes
//   i_load   in   capture i_data into every lane (has priority over shift)
//   i_shift  in   arithmetic-shift every lane right by one bit
//   i_data   in   K x W activation vector
//   o_lsb    out  current LSB column, bit k = LSB of lane k
// -----------------------------------------------------------------------------
module da_bitplane_sreg #(
  parameter int W = 16,
  parameter int K = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [K-1:0][W-1:0]   i_data,
  output logic [K-1:0]          o_lsb
);

  logic [K-1:0][W-1:0] r_lanes;

  // Replicating the MSB on each shift sign-extends the lane, so after W-1
  // shifts the LSB column carries the true sign bit of every activation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lanes <= '0;
    end else if (i_load) begin
      r_lanes <= i_data;
    end else if (i_shift) begin
      for (int k = 0; k < K; k++) begin
        r_lanes[k] <= {r_lanes[k][W-1], r_lanes[k][W-1:1]};
      end
    end
  end

  always_comb begin
    o_lsb = '0;
    for (int k = 0; k < K; k++) begin
      o_lsb[k] = r_lanes[k][0];
    end
  end

endmodule

// File: rtl/da_addr_gen.sv
// -----------------------------------------------------------------------------
// da_addr_gen
// Bit-serial address generator for the DA LUT stage. Holds one vector of K
// signed activations and presents one bit-plane per cycle, LSB first.
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   i_a_in        in   K x DATA_WIDTH_A activation vector
//   i_in_valid    in   i_a_in is valid
//   o_in_ready    out  a vector can be accepted this cycle
//   i_out_ready   in   consumer accepts the current slice
//   o_a0          out  bit t of activation 0
//   o_addr_array  out  bit i-1 = ~(x_i[t] ^ x_0[t])
//   o_t           out  bit index of current slice
//   o_gen_done    out  slice valid
//   o_last_slice  out  current slice is the sign (MSB) slice
//   o_busy        out  a vector is held
// -----------------------------------------------------------------------------
module da_addr_gen
  import da_pkg::*;
#(
  parameter int DATA_WIDTH_A = DATA_WIDTH_A_DEF,
  parameter int K            = K_DEF,
  parameter int T_W          = T_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [K-1:0][DATA_WIDTH_A-1:0]  i_a_in,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic                            i_out_ready,
  output logic                            o_a0,
  output logic [K-2:0]                    o_addr_array,
  output logic [T_W-1:0]                  o_t,
  output logic                            o_gen_done,
  output logic                            o_last_slice,
  output logic                            o_busy
);

  localparam logic [T_W-1:0] LAST_T = T_W'(DATA_WIDTH_A - 1);

  da_gen_state_t  r_state;
  da_gen_state_t  w_next_state;
  logic [T_W-1:0] r_t;
  logic [K-1:0]   w_lsb;
  logic           w_shift_mode;
  logic           w_last;
  logic           w_hs;
  logic           w_in_ready;
  logic           w_load;
  logic           w_shift;

  // A new vector can be taken while idle, or in the same cycle the sign
  // slice is accepted, which gives back-to-back vectors with no bubble.
  assign w_shift_mode = (r_state == SHIFT);
  assign w_last       = w_shift_mode && (r_t == LAST_T);
  assign w_hs         = w_shift_mode && i_out_ready;
  assign w_in_ready   = (r_state == IDLE) || (w_last && i_out_ready);
  assign w_load       = i_in_valid && w_in_ready;
  assign w_shift      = w_hs && !w_last;

  da_bitplane_sreg #(
    .W (DATA_WIDTH_A),
    .K (K)
  ) u_sreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (i_a_in),
    .o_lsb   (w_lsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_t <= '0;
      end else if (w_hs) begin
        r_t <= w_last ? '0 : (r_t + T_W'(1));
      end
    end
  end

  // Slice outputs are forced to zero outside SHIFT so the consumer sees a
  // clean all-zero bus whenever gen_done is low.
  always_comb begin
    w_next_state = r_state;
    o_a0         = 1'b0;
    o_addr_array = '0;
    case (r_state)
      IDLE: begin
        if (w_load) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (w_hs && w_last) w_next_state = w_load ? SHIFT : IDLE;
        o_a0 = w_lsb[0];
        for (int i = 1; i < K; i++) begin
          o_addr_array[i-1] = ~(w_lsb[i] ^ w_lsb[0]);
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign o_in_ready   = w_in_ready;
  assign o_gen_done   = w_shift_mode;
  assign o_last_slice = w_last;
  assign o_busy       = w_shift_mode;
  assign o_t          = r_t;

endmodule

// File: tb/tb_da_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_da_addr_gen
// Directed bench for da_addr_gen (K=9, DATA_WIDTH_A=16). Stimulus pushes the
// expected slices into a queue; a monitor pops one entry per accepted slice
// and also rebuilds every lane from A0/addr_array, weighting the sign slice
// negatively, to compare against the vector that was sent.
// -----------------------------------------------------------------------------
module tb_da_addr_gen;
  import da_pkg::*;

  localparam int W  = 16;
  localparam int KK = 9;

  typedef logic [KK-1:0][W-1:0] vec_t;

  typedef struct {
    logic       a0;
    logic [7:0] addr;
    int         t;
    logic       last;
  } exp_t;

  logic              clk;
  logic              rst;
  vec_t              i_a_in;
  logic              i_in_valid;
  logic              o_in_ready;
  logic              i_out_ready;
  logic              o_a0;
  logic [KK-2:0]     o_addr_array;
  logic [7:0]        o_t;
  logic              o_gen_done;
  logic              o_last_slice;
  logic              o_busy;

  int   total = 0;
  int   bad   = 0;
  int   cycleCnt = 0;
  exp_t expQ[$];
  vec_t refQ[$];
  int   hsCycles[$];
  int   acc[KK];

  da_addr_gen #(.DATA_WIDTH_A(W), .K(KK), .T_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_a_in       (i_a_in),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_out_ready  (i_out_ready),
    .o_a0         (o_a0),
    .o_addr_array (o_addr_array),
    .o_t          (o_t),
    .o_gen_done   (o_gen_done),
    .o_last_slice (o_last_slice),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  task automatic pushExpect(input logic a0, input logic [7:0] addr, input int t);
    exp_t e;
    e.a0 = a0; e.addr = addr; e.t = t; e.last = (t == W-1);
    expQ.push_back(e);
  endtask

  task automatic pushModel(input vec_t v);
    logic [KK-1:0] bits;
    for (int t = 0; t < W; t++) begin
      for (int i = 0; i < KK; i++) bits[i] = v[i][t];
      pushExpect(bits[0], slice_addr(bits), t);
    end
  endtask

  // Presents a vector and returns just after the edge that loads it.
  task automatic applyStimulus(input vec_t v);
    bit ok = 0;
    refQ.push_back(v);
    i_a_in     = v;
    i_in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (o_in_ready) ok = 1;
    end
    if (!ok) begin
      checkOutput("in_ready_timeout", 32'd0, 32'd1);
      i_in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      i_a_in     = {KK{16'($urandom)}};
    end
  endtask

  task automatic waitIdle();
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk);
      #1;
      if (!o_busy && expQ.size() == 0) ok = 1;
    end
    if (!ok) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitT(input int tv);
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (o_gen_done && o_t == 8'(tv)) ok = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) checkOutput("wait_t_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: one pop per accepted slice.
  always @(negedge clk) begin
    if (!rst && o_gen_done && i_out_ready) begin
      hsCycles.push_back(cycleCnt);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_slice", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("A0", 32'(o_a0), 32'(e.a0));
        checkOutput("addr_array", 32'(o_addr_array), 32'(e.addr));
        checkOutput("t", 32'(o_t), 32'(e.t));
        checkOutput("last_slice", 32'(o_last_slice), 32'(e.last));
        if (e.t == 0) for (int i = 0; i < KK; i++) acc[i] = 0;
        for (int i = 0; i < KK; i++) begin
          logic xb;
          xb = (i == 0) ? o_a0 : (~o_addr_array[i-1] ^ o_a0);
          if (xb) begin
            if (e.last) acc[i] = acc[i] - (1 << e.t);
            else        acc[i] = acc[i] + (1 << e.t);
          end
        end
        if (e.last) begin
          if (refQ.size() == 0) begin
            checkOutput("ref_missing", 32'd1, 32'd0);
          end else begin
            vec_t rv;
            rv = refQ.pop_front();
            for (int i = 0; i < KK; i++)
              checkOutput("lane_rebuild", 32'(acc[i]), 32'(int'($signed(rv[i]))));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v, v2;
    logic [KK-1:0] bits;

    rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b1; i_a_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_gen_done", 32'(o_gen_done), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_in_ready", 32'(o_in_ready), 32'd1);
    checkOutput("rst_t", 32'(o_t), 32'd0);
    checkOutput("rst_a0", 32'(o_a0), 32'd0);
    checkOutput("rst_addr", 32'(o_addr_array), 32'd0);
    checkOutput("rst_last", 32'(o_last_slice), 32'd0);
    rst = 1'b0;

    $display("[TB] all lanes = 1");
    for (int i = 0; i < KK; i++) v[i] = 16'd1;
    pushExpect(1'b1, 8'hFF, 0);
    for (int t = 1; t < W; t++) pushExpect(1'b0, 8'hFF, t);
    applyStimulus(v);
    waitIdle();
    checkOutput("done_low_after", 32'(o_gen_done), 32'd0);

    $display("[TB] lane0 = -1, others 0");
    v = '0; v[0] = 16'hFFFF;
    for (int t = 0; t < W; t++) pushExpect(1'b1, 8'h00, t);
    applyStimulus(v);
    waitIdle();

    $display("[TB] back-to-back");
    for (int i = 0; i < KK; i++) v[i]  = 16'(16'h1234 * (i + 1));
    for (int i = 0; i < KK; i++) v2[i] = 16'(16'h8001 + 16'h0F0F * i);
    v2[8] = 16'h7FFF; v2[7] = 16'h8000;
    hsCycles.delete();
    pushModel(v);
    pushModel(v2);
    applyStimulus(v);
    applyStimulus(v2);
    waitIdle();
    checkOutput("b2b_slices", 32'(hsCycles.size()), 32'd32);
    if (hsCycles.size() == 32)
      checkOutput("b2b_span", 32'(hsCycles[31] - hsCycles[0]), 32'd31);

    $display("[TB] backpressure at t=7");
    for (int i = 0; i < KK; i++) v[i] = 16'(16'h00A5 << (i % 4)) ^ 16'(i * 16'h0101);
    pushModel(v);
    for (int i = 0; i < KK; i++) bits[i] = v[i][7];
    applyStimulus(v);
    waitT(7);
    i_out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("hold_t", 32'(o_t), 32'd7);
      checkOutput("hold_a0", 32'(o_a0), 32'(bits[0]));
      checkOutput("hold_addr", 32'(o_addr_array), 32'(slice_addr(bits)));
      checkOutput("hold_valid", 32'(o_gen_done), 32'd1);
    end
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resume_t", 32'(o_t), 32'd8);
    waitIdle();

    $display("[TB] reset mid-vector at t=9");
    for (int i = 0; i < KK; i++) v[i] = 16'($urandom);
    pushModel(v);
    applyStimulus(v);
    waitT(9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    refQ.delete();
    checkOutput("mid_rst_gen_done", 32'(o_gen_done), 32'd0);
    checkOutput("mid_rst_t", 32'(o_t), 32'd0);
    checkOutput("mid_rst_busy", 32'(o_busy), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(o_in_ready), 32'd1);
    for (int i = 0; i < KK; i++) v[i] = 16'(16'hC35A + i * 16'h1111);
    pushModel(v);
    applyStimulus(v);
    waitIdle();

    $display("[TB] random vectors");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < KK; i++) v[i] = 16'($urandom);
      pushModel(v);
      applyStimulus(v);
      waitIdle();
    end

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/da_addr_gen.md
Name: da_addr_gen

Overview:
- Bit-serial address generator that feeds the DA LUT stage of the CNN datapath.
- Accepts one vector of K signed activations, stores it, and emits one bit-plane per cycle, LSB first, in offset-binary form:
  - A0: sign-select bit.
  - addr_array: K-1 relative-sign bits.
  - t: current bit index.
  - gen_done: slice-valid qualifier.
- Downstream, the LUT sums ±B/2 terms and the shift-accumulator weights each slice by 2^t. The MSB slice is flagged so the accumulator subtracts it.

Parameters:
- DATA_WIDTH_A, 16, activation width in bits; legal range 2..255.
- K, 9, activations per vector; must match the LUT stage's K; K ≥ 2.
- T_W, 8, width of the t output; DATA_WIDTH_A-1 must fit in T_W bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- A_in  in  K x DATA_WIDTH_A, signed array  activation vector.
- in_valid  in  1  A_in is valid.
- in_ready  out  1  block can accept A_in this cycle.
- out_ready  in  1  consumer (LUT + accumulator) accepts the current slice.
- A0  out  1  x_0[t], the bit of activation 0 at position t.
- addr_array  out  K-1  bit i-1 = ~(x_i[t] ^ x_0[t]), for i = 1..K-1.
- t  out  T_W  bit index of the current slice, 0..DATA_WIDTH_A-1.
- gen_done  out  1  slice valid.
- last_slice  out  1  high with gen_done when t == DATA_WIDTH_A-1 (sign slice).
- busy  out  1  a vector is held (state != IDLE).

Behaviour:
- Reset (rst=1 at clk edge):
  - State returns to IDLE.
  - gen_done=0, last_slice=0, A0=0, addr_array=0, t=0, busy=0.
  - in_ready=1 is driven combinationally from IDLE.
  - Reset mid-vector discards the held vector; no further slices are emitted.
- States: IDLE and SHIFT.
- IDLE:
  - in_ready=1, gen_done=0.
  - On in_valid: register A_in into the shift register, set t=0, go to SHIFT.
  - The first slice is valid the next cycle (latency 1).
- SHIFT:
  - gen_done=1.
  - Outputs are registered, derived from the current LSBs of the shift register. A0, addr_array and t are stable while out_ready=0.
  - Slice handshake = gen_done & out_ready.
  - On handshake with t < DATA_WIDTH_A-1: arithmetic-right-shift every element by 1 and increment t.
  - On handshake with t == DATA_WIDTH_A-1 (last_slice=1): vector complete.
- in_ready in SHIFT = last_slice & out_ready (combinational).
  - If in_valid is also high: load the new vector, set t=0, stay in SHIFT. Back-to-back vectors leave zero bubble cycles.
  - Otherwise: go to IDLE; gen_done drops next cycle.
- Throughput: DATA_WIDTH_A cycles per vector with no stalls.
- A_in is sampled only on an in_valid & in_ready edge. Changes to A_in at other times have no effect.
- Sign extension by arithmetic shift makes the MSB slice the true sign bit. No extra extension slice is generated.
- t never exceeds DATA_WIDTH_A-1, so it does not wrap.
- in_valid while busy without last-slice acceptance is ignored; the producer holds in_valid.
- Width rule: addr_array is exactly K-1 bits. Bit ordering matches the LUT pairing: bit j pairs with weight j+1.

Decomposition:
- Package da_pkg holds:
  - localparams for default DATA_WIDTH_A, K, T_W.
  - typedef enum logic [0:0] {IDLE, SHIFT} da_gen_state_t.
  - function slice_addr(bits) returning the K-1 relative-sign vector, shared with the LUT-stage bench model.
- One natural sub-module: da_bitplane_sreg, the K-lane arithmetic shift register with load/shift enables, exposing the LSB column.

Test Plan:
- Reset then single vector, K=9, W=16, all A_in=1, out_ready=1:
  - slice t=0: A0=1, addr_array=8'hFF.
  - slices t=1..15: A0=0, addr_array=8'hFF.
  - last_slice at t=15; gen_done low from cycle 17.
- A_in[0]=-1 (16'hFFFF), others 0:
  - every slice: A0=1, addr_array=8'h00.
  - last_slice=1 at t=15.
- Back-to-back:
  - Second vector presented with in_valid held during the first vector's last slice.
  - Next cycle t=0 of the new vector; gen_done never drops; 32 slices in 32 cycles.
- Backpressure: out_ready=0 for 5 cycles at t=7 → A0, addr_array and t hold; t=8 follows the first ready cycle.
- rst asserted at t=9 → next cycle gen_done=0, t=0, busy=0, in_ready=1. A fresh vector then restarts from t=0.
- Random vectors:
  - Σ over t of 2^t · (±) reconstructs each A_in lane exactly, with the MSB slice weighted negative.
  - This checks addr_array and A0 against the da_pkg model.
